// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents: register offsets within the 16-byte window, store-size encodings on WWHBS,
// the transmit FSM state type, STATUS bit positions and a baud-period helper.
package uart_tx_pkg;

  localparam logic [3:0] TXDATA_OFS  = 4'h0;
  localparam logic [3:0] STATUS_OFS  = 4'h4;
  localparam logic [3:0] BAUDDIV_OFS = 4'h8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;

  // A programmed divisor of 0 behaves as 1 cycle per bit.
  function automatic logic [15:0] eff_period(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Core data-memory bus as seen by the UART transmitter.
// Signals: WE/WADDR/WData/WWHBS (store), MRE/RADDR (load request), RDATA (registered load data).
// master: the core side; slave: the peripheral side.
interface uart_tx_mmio_if;
  logic        WE;
  logic [31:0] WADDR;
  logic [31:0] WData;
  logic [1:0]  WWHBS;
  logic        MRE;
  logic [31:0] RADDR;
  logic [31:0] RDATA;

  modport master (
    output WE, WADDR, WData, WWHBS, MRE, RADDR,
    input  RDATA
  );

  modport slave (
    input  WE, WADDR, WData, WWHBS, MRE, RADDR,
    output RDATA
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, Depth a power of two (>= 2).
// Ports: clk_i, rst_ni (async active-low), push_i/wdata_i, pop_i/rdata_o (first-word
// fall-through head), full_o, empty_o, count_o (0..Depth).
// A push while full is accepted only when a pop happens at the same edge; pops on an
// empty FIFO are ignored.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [Aw:0]      count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wptr_q, rptr_q;
  logic [Aw:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (Aw+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + Aw'(1);
      if (do_pop)  rptr_q <= rptr_q + Aw'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (Aw+1)'(1);
        2'b01:   count_q <= count_q - (Aw+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter.
// Ports: CLK, rst_n (async active-low), bus (core store/load bus, slave side),
//        TXD (serial out, idle high), TxIrq (FIFO empty and transmitter idle).
// Window at BASE_ADDR: 0x0 TXDATA (W), 0x4 STATUS (R/W1C overflow), 0x8 BAUDDIV (R/W, half/word
// writes only), 0xC reserved. RDATA is registered and 0 for loads outside the window.
module uart_tx_mmio
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic           CLK,
  input  logic           rst_n,
  uart_tx_mmio_if.slave  bus,
  output logic           TXD,
  output logic           TxIrq
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  // Address decode
  logic       w_hit, r_hit;
  logic [1:0] w_ofs, r_ofs;
  logic       push_req, stat_wr, baud_wr;

  assign w_hit    = bus.WE  && (bus.WADDR[31:4] == BASE_ADDR[31:4]);
  assign r_hit    = bus.MRE && (bus.RADDR[31:4] == BASE_ADDR[31:4]);
  assign w_ofs    = bus.WADDR[3:2];
  assign r_ofs    = bus.RADDR[3:2];
  assign push_req = w_hit && (w_ofs == TXDATA_OFS[3:2]);
  assign stat_wr  = w_hit && (w_ofs == STATUS_OFS[3:2]);
  assign baud_wr  = w_hit && (w_ofs == BAUDDIV_OFS[3:2]) &&
                    ((bus.WWHBS == SZ_HALF) || (bus.WWHBS == SZ_WORD));

  logic unused_bits;
  assign unused_bits = ^{bus.WADDR[1:0], bus.RADDR[1:0], bus.WData[31:16]};

  // Transmit FIFO
  logic            fifo_full, fifo_empty, pop;
  logic [7:0]      fifo_head;
  logic [CntW-1:0] fifo_count;

  sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (rst_n),
    .push_i  (push_req),
    .wdata_i (bus.WData[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Transmitter state
  tx_state_e   state_q;
  logic        txd_q;
  logic [7:0]  shift_q;
  logic [2:0]  bitidx_q;
  logic [15:0] cnt_q, period_q;
  logic        bit_end;

  assign bit_end = (cnt_q == 16'd0);
  // A frame starts from IDLE, or directly out of a finishing stop bit so frames abut.
  assign pop = ~fifo_empty & ((state_q == StIdle) | ((state_q == StStop) & bit_end));

  // Register file
  logic [15:0] bauddiv_q, bauddiv_d;
  logic        ovf_q, ovf_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] status_w;

  always_comb begin
    status_w                      = '0;
    status_w[STAT_FULL]           = fifo_full;
    status_w[STAT_EMPTY]          = fifo_empty;
    status_w[STAT_BUSY]           = (state_q != StIdle);
    status_w[STAT_OVF]            = ovf_q;
    status_w[STAT_CNT_LSB +: 4]   = 4'(fifo_count);
  end

  always_comb begin
    ovf_d     = ovf_q;
    bauddiv_d = bauddiv_q;
    rdata_d   = '0;
    if (stat_wr && bus.WData[STAT_OVF]) ovf_d = 1'b0;
    // A fresh drop wins over a simultaneous clear.
    if (push_req && fifo_full && !pop) ovf_d = 1'b1;
    if (baud_wr) bauddiv_d = bus.WData[15:0];
    if (r_hit) begin
      case (r_ofs)
        STATUS_OFS[3:2]:  rdata_d = status_w;
        BAUDDIV_OFS[3:2]: rdata_d = {16'd0, bauddiv_q};
        default:          rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      bauddiv_q <= DIV_RESET;
      ovf_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      bauddiv_q <= bauddiv_d;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
    end
  end

  // Frame FSM; the period is latched at frame start so BAUDDIV writes wait for the next frame.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      txd_q    <= 1'b1;
      shift_q  <= '0;
      bitidx_q <= '0;
      cnt_q    <= '0;
      period_q <= 16'd1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q  <= StStart;
            txd_q    <= 1'b0;
            shift_q  <= fifo_head;
            period_q <= eff_period(bauddiv_q);
            cnt_q    <= eff_period(bauddiv_q) - 16'd1;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q  <= StData;
            txd_q    <= shift_q[0];
            bitidx_q <= 3'd0;
            cnt_q    <= period_q - 16'd1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q <= period_q - 16'd1;
            if (bitidx_q == 3'd7) begin
              state_q <= StStop;
              txd_q   <= 1'b1;
            end else begin
              bitidx_q <= bitidx_q + 3'd1;
              txd_q    <= shift_q[1];
              shift_q  <= {1'b0, shift_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        StStop: begin
          if (bit_end) begin
            if (pop) begin
              state_q  <= StStart;
              txd_q    <= 1'b0;
              shift_q  <= fifo_head;
              period_q <= eff_period(bauddiv_q);
              cnt_q    <= eff_period(bauddiv_q) - 16'd1;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign TXD       = txd_q;
  assign TxIrq     = fifo_empty & (state_q == StIdle);
  assign bus.RDATA = rdata_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed steps plus randomized bursts. Expected TXD is kept as a
// queue of per-cycle levels built from the byte values and bit periods; every negedge tick
// compares TXD against the head of that queue while it is non-empty.
module tb_uart_tx_mmio;
  import uart_tx_pkg::*;

  localparam logic [31:0] Base  = 32'h1000_0000;
  localparam int unsigned Depth = 8;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  logic TXD, TxIrq;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .BASE_ADDR  (Base),
    .FIFO_DEPTH (Depth),
    .DIV_RESET  (16'd868)
  ) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus),
    .TXD   (TXD),
    .TxIrq (TxIrq)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  bit lvq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (lvq.size() > 0) begin
      bit e;
      e = lvq.pop_front();
      check("txd", {31'd0, TXD}, {31'd0, e});
    end
    @(negedge CLK);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] size);
    bus.WE    = 1'b1;
    bus.WADDR = addr;
    bus.WData = data;
    bus.WWHBS = size;
    tick();
    bus.WE    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.MRE   = 1'b1;
    bus.RADDR = addr;
    tick();
    bus.MRE   = 1'b0;
    data      = bus.RDATA;
  endtask

  // One 8N1 frame: start, eight data bits LSB first, stop; each held p cycles.
  task automatic push_frame(input logic [7:0] b, input int p);
    for (int i = 0; i < 10; i++) begin
      bit lvl;
      lvl = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      repeat (p) lvq.push_back(lvl);
    end
  endtask

  // Idle line at the push-edge tick and the one after it, before the start bit appears.
  task automatic lead_in();
    lvq.push_back(1'b1);
    lvq.push_back(1'b1);
  endtask

  task automatic drain();
    while (lvq.size() > 0) tick();
  endtask

  function automatic logic [31:0] status_exp(input bit full, input bit empty, input bit busy,
                                             input bit ovf, input int cnt);
    return {24'd0, 4'(cnt), ovf, busy, empty, full};
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [15:0] div;
    logic [7:0]  b [10];
    int          k, acc, p;

    bus.WE = 1'b0; bus.WADDR = '0; bus.WData = '0; bus.WWHBS = SZ_WORD;
    bus.MRE = 1'b0; bus.RADDR = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("txd_rst", {31'd0, TXD}, 32'd1);
    check("irq_rst", {31'd0, TxIrq}, 32'd1);
    check("rdata_rst", bus.RDATA, 32'd0);
    rst_n = 1'b1;
    @(negedge CLK);
    bus_read(Base + 32'h4, rd); check("status_rst", rd, 32'h2);
    bus_read(32'h2000_0004, rd); check("read_miss", rd, 32'h0);
    bus_read(Base + 32'h8, rd); check("baud_rst", rd, 32'd868);
    bus_read(Base + 32'hC, rd); check("reg_c", rd, 32'h0);

    // Single 0x55 frame at 4 cycles per bit, byte taken from WData[7:0]
    bus_write(Base + 32'h8, 32'd4, SZ_WORD);
    lead_in(); push_frame(8'h55, 4);
    bus_write(Base, 32'hABCD_EF55, SZ_BYTE);
    check("irq_after_push", {31'd0, TxIrq}, 32'd0);
    bus_read(Base + 32'h4, rd); check("status_pre_pop", rd, status_exp(0, 0, 0, 0, 1));
    bus_read(Base + 32'h4, rd); check("status_busy", rd, status_exp(0, 1, 1, 0, 0));
    drain();
    check("irq_frame_end", {31'd0, TxIrq}, 32'd1);
    bus_read(Base + 32'h4, rd); check("status_frame_end", rd, 32'h2);

    // Overflow: ten word writes at a long period
    bus_write(Base + 32'h8, 32'd1000, SZ_WORD);
    for (int i = 0; i < 10; i++) bus_write(Base, 32'h30 + 32'(i), SZ_WORD);
    bus_read(Base + 32'h4, rd); check("status_overflow", rd, status_exp(1, 0, 1, 1, Depth));
    bus_write(Base + 32'h4, 32'h8, SZ_WORD);
    bus_read(Base + 32'h4, rd); check("status_ovf_clr", rd, status_exp(1, 0, 1, 0, Depth));
    rst_n = 1'b0;
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    bus_read(Base + 32'h4, rd); check("status_flushed", rd, 32'h2);

    // Two abutting frames at 2 cycles per bit
    bus_write(Base + 32'h8, 32'd2, SZ_HALF);
    lead_in(); push_frame(8'hA0, 2); push_frame(8'h0F, 2);
    bus_write(Base, 32'h0000_00A0, SZ_BYTE);
    bus_write(Base, 32'h0000_000F, SZ_HALF);
    drain();
    check("irq_pair_end", {31'd0, TxIrq}, 32'd1);

    // Byte write to BAUDDIV ignored; half write mid-frame applies to the next frame only
    bus_write(Base + 32'h8, 32'h0000_00FF, SZ_BYTE);
    bus_read(Base + 32'h8, rd); check("baud_byte_ignored", rd, 32'd2);
    lead_in(); push_frame(8'h33, 2); push_frame(8'h5A, 3);
    bus_write(Base, 32'h33, SZ_WORD);
    repeat (5) tick();
    bus_write(Base + 32'h8, 32'hFFFF_0003, SZ_HALF);
    bus_write(Base, 32'h5A, SZ_BYTE);
    drain();
    bus_read(Base + 32'h8, rd); check("baud_half", rd, 32'd3);

    // Reset during data bit 3 of 0x55 with a second byte still queued
    bus_write(Base + 32'h8, 32'd4, SZ_WORD);
    lead_in(); push_frame(8'h55, 4);
    bus_write(Base, 32'h55, SZ_BYTE);
    bus_write(Base, 32'hC3, SZ_BYTE);
    repeat (19) tick();
    check("txd_bit3", {31'd0, TXD}, {31'd0, lvq[0]});
    rst_n = 1'b0;
    #1;
    check("txd_async_rst", {31'd0, TXD}, 32'd1);
    lvq.delete();
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    bus_read(Base + 32'h4, rd); check("status_after_rst", rd, 32'h2);
    check("irq_after_rst", {31'd0, TxIrq}, 32'd1);
    repeat (60) lvq.push_back(1'b1);
    drain();
    bus_read(Base + 32'h8, rd); check("baud_after_rst", rd, 32'd868);

    // Randomized bursts into an idle block
    for (int it = 0; it < 8; it++) begin
      div = 16'($urandom_range(0, 3));
      k   = int'($urandom_range(1, 10));
      p   = (div == 16'd0) ? 1 : int'(div);
      acc = (k > Depth + 1) ? Depth + 1 : k;
      bus_write(Base + 32'h8, {16'($urandom), div}, SZ_WORD);
      lead_in();
      for (int i = 0; i < k; i++) begin
        b[i] = 8'($urandom);
        if (i < acc) push_frame(b[i], p);
      end
      for (int i = 0; i < k; i++) begin
        bus_write(Base, {24'($urandom), b[i]}, 2'($urandom_range(0, 2)));
      end
      drain();
      check("irq_burst_end", {31'd0, TxIrq}, 32'd1);
      bus_read(Base + 32'h4, rd);
      check("status_burst", rd, status_exp(0, 1, 0, k > Depth + 1, 0));
      if (k > Depth + 1) begin
        bus_write(Base + 32'h4, 32'hFFFF_FFF8, SZ_WORD);
        bus_read(Base + 32'h4, rd); check("status_burst_clr", rd, 32'h2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the core's data-memory port, alongside `Ram`. It decodes the core's write bus (`WE`/`WADDR`/`WData`/`WWHBS`) and read bus (`MRE`/`RADDR`) for its own address window, buffers transmit bytes in a FIFO, and serialises them as 8N1 frames on `TXD`. The top level multiplexes `RDATA` into the core's load path when `RADDR` hits the window.

## Interface
- `BASE_ADDR`, 32'h1000_0000, base of the 16-byte register window (bits [3:0] ignored for decode).
- `FIFO_DEPTH`, 8, transmit FIFO entries; power of two, minimum 2.
- `DIV_RESET`, 16'd868, reset value of BAUDDIV (100 MHz / 115200).
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `WE`  in  1  core store strobe.
- `WADDR`  in  32  store address.
- `WData`  in  32  store data, right-aligned.
- `WWHBS`  in  2  store size: 00 byte, 01 half, 10 word.
- `MRE`  in  1  core load strobe.
- `RADDR`  in  32  load address.
- `RDATA`  out  32  registered load data; 0 when the load missed the window.
- `TXD`  out  1  serial output, idle high.
- `TxIrq`  out  1  high while the FIFO is empty and the FSM is IDLE.

## Operation
- Registers at BASE+offset:
  - 0x0 TXDATA (W): pushes `WData[7:0]` for any size.
  - 0x4 STATUS (R/W1C): bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[7:4] FIFO count. Writing 1 to bit3 clears it. All other bits read 0.
  - 0x8 BAUDDIV (R/W): bits[15:0] give the bit period in cycles; 0 is treated as 1. Byte-size writes are ignored.
  - 0xC: reads 0, writes ignored.
- Push when `WE` hits TXDATA:
  - Accepted if the FIFO is not full, or if it is full and a pop happens at the same edge.
  - Otherwise the data is dropped and overflow is set.
- FSM states IDLE, START, DATA, STOP:
  - IDLE → START when the FIFO is non-empty at the edge. That edge pops the head into the shift register and latches BAUDDIV into the period register.
  - START: `TXD` = 0 for one period.
  - DATA: 8 periods, LSB first, with a 3-bit bit index.
  - STOP: `TXD` = 1 for one period, then IDLE.
- A 16-bit down-counter times each period.
- There is no FIFO bypass: a pop only happens from a FIFO that was non-empty before the edge.
- Writing BAUDDIV mid-frame takes effect at the next frame start.

## Timing
- Reset values:
  - Outputs: `TXD`=1, `RDATA`=0, `TxIrq`=1.
  - Internal: FIFO empty, overflow=0, BAUDDIV=`DIV_RESET`, FSM IDLE.
- A reset asserted mid-frame aborts the frame immediately (`TXD` goes high asynchronously) and discards the FIFO contents.
- Load latency is 1 cycle: `RDATA` is valid in the cycle after the edge sampling `MRE`. STATUS reflects state before that edge.
- Write to an empty, idle block at edge N:
  - Count becomes 1 after N.
  - Pop at edge N+1; `TXD` falls after N+1.
  - busy=1 from N+1.
- Frame length is exactly 10×period cycles. The next frame's start bit follows the stop bit with no gap if the FIFO is non-empty.
- `TxIrq` deasserts after the pushing edge and reasserts after the edge that ends STOP with the FIFO empty.

## Structure
- Package `uart_tx_pkg` holds:
  - register offsets (`TXDATA_OFS`, `STATUS_OFS`, `BAUDDIV_OFS`),
  - the WWHBS encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`),
  - the FSM state enum,
  - STATUS bit positions.
- Sub-module `sync_fifo` (parameters width 8 and `FIFO_DEPTH`; push/pop/full/empty/count), reusable elsewhere.
- Top of block contains: address decode, register file, baud counter and FSM.

## Test plan
- Reset, then read STATUS → 0x0000_0002. `TXD`=1, `TxIrq`=1.
- BAUDDIV=4, write 0x55 → `TXD` = 0 then 1,0,1,0,1,0,1,0 then 1, each for 4 cycles (40 cycles total). busy clears at the end; `TxIrq` reasserts.
- BAUDDIV=1000, 10 back-to-back word writes to TXDATA:
  - First write pops; next 8 fill the FIFO; 10th is dropped.
  - STATUS read → count 8, full=1, overflow=1, busy=1.
  - Write STATUS 0x8 → overflow=0.
- Two bytes 0xA0, 0x0F at BAUDDIV=2 → 40 contiguous cycles, second start bit immediately after the first stop bit.
- Byte write to BAUDDIV is ignored (read back unchanged). Half write 0x0003 → next frame uses 3-cycle bits; the current frame is unaffected.
- Drop `rst_n` during DATA bit 3 → `TXD`=1 immediately. After release, STATUS = 0x2 and no residual frame appears.
